// File: rtl/bb_raster_pkg.sv
// Shared constants, opcodes, FSM states and the framebuffer address mapping
// for the back-buffer raster writer.
package bb_raster_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int FB_DEPTH = SCREEN_W * SCREEN_H;
    localparam int ADDR_W   = $clog2(FB_DEPTH);
    localparam int X_W      = 9;
    localparam int Y_W      = 8;

    localparam logic [1:0] OP_CLEAR     = 2'b00;
    localparam logic [1:0] OP_LINE      = 2'b01;
    localparam logic [1:0] OP_FRAME_END = 2'b10;
    localparam logic [1:0] OP_RSVD      = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LINE,
        DONE_WAIT,
        SWAP_WAIT
    } state_t;

    // Column-major layout: addr = y + 240*x, with x*240 built from shifts.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] x_hi;
        logic [ADDR_W-1:0] x_lo;
        logic [ADDR_W-1:0] y_ext;
        x_hi  = ADDR_W'({x, 8'b0});
        x_lo  = ADDR_W'({x, 4'b0});
        y_ext = ADDR_W'(y);
        return x_hi - x_lo + y_ext;
    endfunction

endpackage

// File: rtl/bb_raster_writer_stepper.sv
// Bresenham line walker: loads the endpoints, then advances one pixel per step.
module bresenham_stepper
    import bb_raster_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last,
    output logic           in_range
);

    logic [X_W-1:0]     x_reg, x1_reg, x_next;
    logic [Y_W-1:0]     y_reg, y1_reg, y_next;
    logic signed [10:0] dx_reg, dy_reg, err_reg;
    logic signed [10:0] dx_load, dy_load, e2, err_next;
    logic               sx_neg_reg, sy_neg_reg;

    always_comb begin
        dx_load = (x1 >= x0) ? $signed(11'(x1 - x0)) : $signed(11'(x0 - x1));
        dy_load = (y1 >= y0) ? -$signed(11'(y1 - y0)) : -$signed(11'(y0 - y1));

        // Both corrections use the same e2 and are applied in one cycle.
        e2       = err_reg <<< 1;
        err_next = err_reg;
        x_next   = x_reg;
        y_next   = y_reg;
        if (e2 >= dy_reg) begin
            err_next = err_next + dy_reg;
            x_next   = sx_neg_reg ? x_reg - X_W'(1) : x_reg + X_W'(1);
        end
        if (e2 <= dx_reg) begin
            err_next = err_next + dx_reg;
            y_next   = sy_neg_reg ? y_reg - Y_W'(1) : y_reg + Y_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_reg      <= '0;
            y_reg      <= '0;
            x1_reg     <= '0;
            y1_reg     <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_neg_reg <= 1'b0;
            sy_neg_reg <= 1'b0;
        end else if (load) begin
            x_reg      <= x0;
            y_reg      <= y0;
            x1_reg     <= x1;
            y1_reg     <= y1;
            dx_reg     <= dx_load;
            dy_reg     <= dy_load;
            err_reg    <= dx_load + dy_load;
            sx_neg_reg <= (x1 < x0);
            sy_neg_reg <= (y1 < y0);
        end else if (step) begin
            x_reg   <= x_next;
            y_reg   <= y_next;
            err_reg <= err_next;
        end
    end

    assign x        = x_reg;
    assign y        = y_reg;
    assign last     = (x_reg == x1_reg) && (y_reg == y1_reg);
    assign in_range = (x_reg < X_W'(SCREEN_W)) && (y_reg < Y_W'(SCREEN_H));

endmodule

// File: rtl/bb_raster_writer.sv
// Back-buffer writer: rasterises CLEAR/LINE commands one pixel per cycle and
// runs the done/swap handshake so the buffer is frozen during the copy.
module bb_raster_writer
    import bb_raster_pkg::*;
#(
    parameter  int NUMBER_COLORS = 9,
    localparam int COLOR_W       = $clog2(NUMBER_COLORS) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [ADDR_W-1:0]  waddr,
    output logic [COLOR_W-1:0] din,
    output logic               bb_we,
    output logic               done,
    input  logic               swap,
    output logic               busy
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [COLOR_W-1:0]  color_reg;
    logic                latch_color;
    logic                load, step;
    logic [X_W-1:0]      px;
    logic [Y_W-1:0]      py;
    logic                px_last, px_in_range;

    bresenham_stepper u_stepper (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .step     (step),
        .x0       (cmd_x0),
        .y0       (cmd_y0),
        .x1       (cmd_x1),
        .y1       (cmd_y1),
        .x        (px),
        .y        (py),
        .last     (px_last),
        .in_range (px_in_range)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            clr_cnt_reg <= '0;
            color_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            if (latch_color) begin
                color_reg <= cmd_color;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        cmd_ready    = 1'b0;
        latch_color  = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        bb_we        = 1'b0;
        waddr        = '0;
        done         = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            state_next   = CLEAR;
                            clr_cnt_next = '0;
                            latch_color  = 1'b1;
                        end
                        OP_LINE: begin
                            state_next  = LINE;
                            load        = 1'b1;
                            latch_color = 1'b1;
                        end
                        OP_FRAME_END: state_next = DONE_WAIT;
                        OP_RSVD:      state_next = IDLE;
                    endcase
                end
            end
            CLEAR: begin
                bb_we = 1'b1;
                waddr = clr_cnt_reg;
                if (clr_cnt_reg == ADDR_W'(FB_DEPTH - 1)) begin
                    state_next = IDLE;
                end else begin
                    clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                end
            end
            LINE: begin
                // Off-screen pixels are skipped but the walk keeps stepping.
                bb_we = px_in_range;
                waddr = xy_to_addr(px, py);
                if (px_last) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE_WAIT: begin
                done = 1'b1;
                if (swap) begin
                    state_next = SWAP_WAIT;
                end
            end
            SWAP_WAIT: begin
                if (!swap) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign din  = color_reg;
    assign busy = (state_reg != IDLE);

endmodule
